// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: RV32M multiply/divide sequencer for a pipelined core.
// Three-state control (IDLE, CALC, FIN). Division is a radix-2 restoring
// divide on operand magnitudes with a final sign fix-up; divide-by-zero and
// signed overflow bypass the iteration. Multiplies are iterative shift-add
// by default; defining MULDIV_FAST_MUL_EN swaps in a single-cycle 64-bit
// multiplier. Result values are identical in both builds.
module muldiv_sequencer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic        FLUSH,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;        // latched FUNCT3
  logic [31:0] a_q, a_d;          // dividend->quotient shift reg, or multiplier
  logic [31:0] b_q, b_d;          // divisor magnitude
  logic [31:0] rem_q, rem_d;      // partial remainder
  logic [63:0] mcand_q, mcand_d;  // shifted multiplicand
  logic [63:0] acc_q, acc_d;      // product accumulator
  logic [4:0]  cnt_q, cnt_d;      // iteration index 0..31
  logic        neg_q, neg_d;      // negate quotient / product
  logic        rneg_q, rneg_d;    // negate remainder
  logic [31:0] result_q, result_d;

  // Operand decode on the live inputs, used only on the accepting edge.
  logic        in_sgn1, in_sgn2, in_neg1, in_neg2;
  logic [31:0] in_mag1, in_mag2;
  logic        in_div_by_zero, in_overflow;

  // One datapath step of the current iteration plus the signed final result.
  logic [32:0] rem_shift;
  logic        sub_ok;
  logic [31:0] div_rem_nx, div_quo_nx, quo_fix, rem_fix;
  logic [63:0] acc_nx, prod_fix;
  logic [31:0] final_result;

`ifdef MULDIV_FAST_MUL_EN
  logic [63:0] fast_prod, fast_fix;
`endif

  // Decode operand signedness, magnitudes and the divide bypass cases.
  always_comb begin
    in_sgn1 = FUNCT3[2] ? ~FUNCT3[0] : (FUNCT3 == OP_MULH || FUNCT3 == OP_MULHSU);
    in_sgn2 = FUNCT3[2] ? ~FUNCT3[0] : (FUNCT3 == OP_MULH);
    in_neg1 = in_sgn1 & DATA1[31];
    in_neg2 = in_sgn2 & DATA2[31];
    in_mag1 = in_neg1 ? (32'd0 - DATA1) : DATA1;
    in_mag2 = in_neg2 ? (32'd0 - DATA2) : DATA2;
    in_div_by_zero = (DATA2 == 32'd0);
    in_overflow    = ~FUNCT3[0] && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle magnitude product with sign applied afterwards.
  always_comb begin
    fast_prod = {32'd0, in_mag1} * {32'd0, in_mag2};
    fast_fix  = (in_neg1 ^ in_neg2) ? (64'd0 - fast_prod) : fast_prod;
  end
`endif

  // One restoring-divide step and one shift-add step, then the signed result.
  always_comb begin
    rem_shift  = {rem_q, a_q[31]};
    sub_ok     = (rem_shift >= {1'b0, b_q});
    // When sub_ok is set the difference is below b_q, so 32 bits suffice.
    div_rem_nx = sub_ok ? (rem_shift[31:0] - b_q) : rem_shift[31:0];
    div_quo_nx = {a_q[30:0], sub_ok};
    acc_nx     = acc_q + (a_q[0] ? mcand_q : 64'd0);

    quo_fix  = neg_q  ? (32'd0 - div_quo_nx) : div_quo_nx;
    rem_fix  = rneg_q ? (32'd0 - div_rem_nx) : div_rem_nx;
    prod_fix = neg_q  ? (64'd0 - acc_nx)     : acc_nx;

    if (op_q[2]) begin
      final_result = op_q[1] ? rem_fix : quo_fix;
    end else if (op_q == OP_MUL) begin
      final_result = prod_fix[31:0];
    end else begin
      final_result = prod_fix[63:32];
    end
  end

  // Next-state and register-update logic for the control FSM and datapath.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (START && !FLUSH) begin
          op_d    = FUNCT3;
          a_d     = FUNCT3[2] ? in_mag1 : in_mag2;
          b_d     = in_mag2;
          rem_d   = 32'd0;
          mcand_d = {32'd0, in_mag1};
          acc_d   = 64'd0;
          cnt_d   = 5'd0;
          neg_d   = in_neg1 ^ in_neg2;
          rneg_d  = in_neg1;
          if (FUNCT3[2]) begin
            if (in_div_by_zero) begin
              result_d = FUNCT3[1] ? DATA1 : 32'hFFFF_FFFF;
              state_d  = S_FIN;
            end else if (in_overflow) begin
              result_d = FUNCT3[1] ? 32'd0 : 32'h8000_0000;
              state_d  = S_FIN;
            end else begin
              state_d  = S_CALC;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            result_d = (FUNCT3 == OP_MUL) ? fast_fix[31:0] : fast_fix[63:32];
            state_d  = S_FIN;
`else
            state_d  = S_CALC;
`endif
          end
        end
      end

      S_CALC: begin
        if (op_q[2]) begin
          a_d   = div_quo_nx;
          rem_d = div_rem_nx;
        end else begin
          a_d     = {1'b0, a_q[31:1]};
          acc_d   = acc_nx;
          mcand_d = {mcand_q[62:0], 1'b0};
        end
        if (cnt_q == 5'd31) begin
          result_d = final_result;
          state_d  = S_FIN;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Flush abandons the operation but keeps the last delivered result.
    if (FLUSH) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: reset clears the datapath too, so no stale operand survives a reset.
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      rem_q    <= 32'd0;
      mcand_q  <= 64'd0;
      acc_q    <= 64'd0;
      cnt_q    <= 5'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  // Outputs decode directly from the registered state.
  always_comb begin
    BUSY   = (state_q != S_IDLE);
    DONE   = (state_q == S_FIN);
    RESULT = result_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus
// randomized operations against an arithmetic reference model. Latency
// expectations follow MULDIV_FAST_MUL_EN when it is defined for the build.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, flush;
  logic [2:0]  funct3;
  logic [31:0] data1, data2;
  logic        busy, done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_result;

  muldiv_sequencer dut (
    .CLK    (clk),
    .RESET  (reset),
    .START  (start),
    .FUNCT3 (funct3),
    .DATA1  (data1),
    .DATA2  (data2),
    .FLUSH  (flush),
    .BUSY   (busy),
    .DONE   (done),
    .RESULT (result)
  );

  always #5 clk = ~clk;

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference result from plain arithmetic on sign-extended operands.
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] d1,
                                             input logic [31:0] d2);
    logic [63:0] x, y, p;
    int          sa, sb;
    int unsigned ua, ub;
    if (!f3[2]) begin
      x = (f3 == 3'b001 || f3 == 3'b010) ? {{32{d1[31]}}, d1} : {32'd0, d1};
      y = (f3 == 3'b001) ? {{32{d2[31]}}, d2} : {32'd0, d2};
      p = x * y;
      return (f3 == 3'b000) ? p[31:0] : p[63:32];
    end
    if (d2 == 32'd0) return f3[1] ? d1 : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (d1 == 32'h8000_0000 && d2 == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
      sa = d1;
      sb = d2;
      return f3[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    ua = d1;
    ub = d2;
    return f3[1] ? (ua % ub) : (ua / ub);
  endfunction

  // Cycles from the accepting edge to the DONE cycle.
  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] d1,
                                     input logic [31:0] d2);
    if (f3[2]) begin
      if (d2 == 32'd0) return 1;
      if (!f3[0] && d1 == 32'h8000_0000 && d2 == 32'hFFFF_FFFF) return 1;
      return 33;
    end
`ifdef MULDIV_FAST_MUL_EN
    return 1;
`else
    return 33;
`endif
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(1, 20));
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called right after a negedge: launch one op, follow it to DONE and one cycle beyond.
  // With poke set, a conflicting START is driven mid-CALC and must be ignored.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] d1,
                        input logic [31:0] d2, input bit poke);
    logic [31:0] exp_res, got_res;
    int          lat, got_lat;
    bit          busy_ok, hold_ok;
    exp_res = ref_result(f3, d1, d2);
    lat     = ref_latency(f3, d1, d2);
    got_lat = 0;
    got_res = 32'd0;
    busy_ok = 1'b1;
    hold_ok = 1'b1;
    start = 1'b1; funct3 = f3; data1 = d1; data2 = d2;
    @(posedge clk);
    #1;
    start = 1'b0; funct3 = 3'($urandom); data1 = $urandom; data2 = $urandom;
    for (int n = 1; n <= 40 && got_lat == 0; n++) begin
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        got_lat = n;
        got_res = result;
      end else if (result !== last_result) begin
        hold_ok = 1'b0;
      end
      if (poke && lat == 33 && n == 5) begin
        start = 1'b1; funct3 = 3'($urandom); data1 = $urandom; data2 = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check({tag, " latency"}, 64'(got_lat), 64'(lat));
    check({tag, " result"}, {32'd0, got_res}, {32'd0, exp_res});
    check({tag, " busy_while_active"}, {63'd0, busy_ok}, 64'd1);
    check({tag, " result_hold"}, {63'd0, hold_ok}, 64'd1);
    @(negedge clk);
    check({tag, " idle_after_fin"}, {30'd0, done, busy, result},
          {32'd0, exp_res});
    last_result = exp_res;
  endtask

  initial begin
    int dones;
    reset = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; data1 = 32'd0; data2 = 32'd0;
    last_result = 32'd0;
    repeat (3) @(negedge clk);
    check("reset outputs", {30'd0, busy, done, result}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed corner cases.
    run_op("div_neg20_3",   3'b100, 32'hFFFF_FFEC, 32'd3, 1'b0);
    run_op("rem_neg20_3",   3'b110, 32'hFFFF_FFEC, 32'd3, 1'b0);
    run_op("divu_by_zero",  3'b101, 32'd100, 32'd0, 1'b0);
    run_op("remu_by_zero",  3'b111, 32'd100, 32'd0, 1'b0);
    run_op("div_overflow",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_overflow",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mulh_m1_m1",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mulhsu_m1_m1",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mulhu_m1_m1",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mul_m1_m1",     3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div_poke",      3'b100, 32'd1000, 32'hFFFF_FFF9, 1'b1);
    run_op("mul_poke",      3'b000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);

    // Flush at CALC cycle 10 of a DIVU: back to IDLE, no DONE, result kept.
    start = 1'b1; funct3 = 3'b101; data1 = 32'd1000; data2 = 32'd7;
    @(posedge clk);
    #1 start = 1'b0;
    dones = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush outputs", {30'd0, busy, done, result}, {32'd0, last_result});
    check("flush no done", 64'(dones), 64'd0);
    run_op("after_flush", 3'b101, 32'd1000, 32'd7, 1'b0);

    // Flush and start together: nothing is accepted.
    start = 1'b1; flush = 1'b1; funct3 = 3'b100; data1 = 32'd77; data2 = 32'd5;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    check("flush_start idle", {62'd0, busy, done}, 64'd0);

    // Randomized operations, back to back.
    for (int i = 0; i < 60; i++) begin
      run_op($sformatf("rand%0d", i), 3'($urandom_range(0, 7)), pick_operand(),
             pick_operand(), (i % 4) == 0);
    end

    // Reset in the middle of CALC: outputs cleared, no DONE afterwards.
    start = 1'b1; funct3 = 3'b100; data1 = 32'hDEAD_BEEF; data2 = 32'd13;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset mid calc", {30'd0, busy, done, result}, 64'd0);
    reset = 1'b0;
    last_result = 32'd0;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    check("no done after reset", 64'(dones), 64'd0);
    run_op("after_reset", 3'b110, 32'hFFFF_FF9C, 32'd7, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
